pipe_flow_ctrl_n: RTL and testbench
===================================

Name: pipe_flow_ctrl_n

Overview:
Parametrised pipeline flow controller, successor to the fixed six-register PC/IF/ID/EX/MEM/WB controller. It generates a write-enable and a bubble/flush reset for each of NUM_REGS pipeline registers. Register 0 is the PC; register k sits at the input of stage k. Adds four things: per-stage stall and flush vectors, a post-reset hold sequencer, a drain/idle FSM for debug halt, and a saturating stall-cycle counter.

Parameters:
NUM_REGS, 6, number of pipeline registers including PC (min 3)
IDX_W, 3, width of redirect stage index (clog2(NUM_REGS))
RESET_HOLD, 4, cycles all reg resets stay asserted after reset release (min 1)
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
stall_req  in  NUM_REGS  bit i: stage i cannot complete this cycle (bit 0 = fetch/ic_stall)
redirect  in  1  control redirect (branch taken/jump/trap) resolved in stage redirect_stage
redirect_stage  in  IDX_W  stage resolving redirect (1..NUM_REGS-1)
drain_req  in  1  level; request pipeline drain then idle
resume  in  1  pulse; leave IDLE
reg_we  out  NUM_REGS  per-register write enable
reg_reset  out  NUM_REGS  per-register bubble/clear, synchronous in consumer
state  out  2  0=HOLD 1=RUN 2=DRAIN 3=IDLE
drained  out  1  high in IDLE
stall_cycles  out  CNT_W  saturating count of cycles with reg_we[0]=0 in RUN

Behaviour:
- Outputs are combinational from the FSM state, the hold counter and the inputs. FSM, counters and stall_cycles are registered.
- While reset=0: state=HOLD, hold_cnt=0, drain_cnt=0, stall_cycles=0. Outputs are reg_we=0, reg_reset=all ones, drained=0.
- HOLD: reg_we=0, reg_reset=all ones. hold_cnt increments each cycle. When hold_cnt==RESET_HOLD-1, move to RUN. Other inputs are ignored.
- RUN, stall rule: s = highest index with stall_req[s]=1.
  - reg_we[0..s]=0.
  - reg_reset[s+1]=1 (bubble) if s+1<NUM_REGS.
  - Registers above s+1: we=1, reset=0.
  - No stall: all we=1, reset=0.
- RUN, redirect rule: when redirect=1 with stage r:
  - reg_reset[1..r]=1, killing younger instructions.
  - reg_we[0]=1 so the PC loads the target.
  - reg_we[1..r] are don't-care-forced to 1.
- Simultaneous stall and redirect, s<r: the redirect wins for regs 0..r. Regs above r follow the stall rule, which has no effect there.
- Simultaneous stall and redirect, s>=r: the stall wins. Redirect is suppressed entirely and the resolving stage re-asserts it next cycle.
- redirect_stage of 0 or >=NUM_REGS: treated as no redirect.
- RUN->DRAIN: on drain_req=1 (registered, next cycle).
- DRAIN:
  - reg_we[0]=0 and reg_reset[1]=1, so no new fetch.
  - Other regs follow the stall and redirect rules; redirect may update the PC but flushed regs stay bubbled.
  - drain_cnt counts cycles with no stall_req[1..NUM_REGS-1]; any such stall holds drain_cnt.
  - When drain_cnt==NUM_REGS-2, go to IDLE.
- DRAIN with drain_req dropped: return to RUN, drain_cnt=0.
- IDLE: reg_we=0, reg_reset=0, drained=1. On resume=1 go to RUN next cycle. drain_req does not hold off resume.
- RUN->IDLE is impossible without DRAIN. resume outside IDLE is ignored.
- stall_cycles increments when state==RUN and reg_we[0]==0. It saturates at all ones with no wrap.
- Reset asserted mid-DRAIN, mid-IDLE or mid-HOLD: returns to HOLD next edge and the full RESET_HOLD sequence reruns.

Test Plan:
- Reset low 3 cycles then high, RESET_HOLD=4 -> reg_reset=6'b111111, reg_we=0 for exactly 4 cycles after release; state=1 on the 5th cycle with reg_we=6'b111111.
- RUN, stall_req=6'b001000 (s=3) -> reg_we=6'b110000, reg_reset=6'b010000; stall_cycles +1 per cycle held.
- RUN, redirect=1, redirect_stage=3, stall_req=6'b000010 -> reg_reset=6'b001110, reg_we[0]=1, stall_cycles unchanged. Same with stall_req=6'b010000 -> redirect suppressed, reg_we=6'b100000, reg_reset=6'b100000.
- drain_req=1 with no stalls, NUM_REGS=6 -> one RUN cycle, 4 DRAIN cycles (reg_we[0]=0, reg_reset[1]=1), then state=3 with drained=1. Repeat with stall_req[4] high 2 cycles mid-drain -> 6 DRAIN cycles.
- Drain aborted (drain_req low after 2 DRAIN cycles) -> state=1 next cycle. In IDLE, pulse resume -> state=1 and reg_we=all ones next cycle.
- CNT_W=4, hold stall_req[0] for 20 RUN cycles -> stall_cycles=15 and stays there. Assert reset in IDLE -> state=0, stall_cycles=0, drained=0 next cycle.

Source files
------------

// File: rtl/pipe_flow_ctrl_n.sv
// pipe_flow_ctrl_n: per-register write-enable/bubble generation with post-reset hold, debug drain/idle and stall counting
module pipe_flow_ctrl_n #(
  parameter int NUM_REGS   = 6,
  parameter int IDX_W      = 3,
  parameter int RESET_HOLD = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REGS-1:0] stall_req,
  input  logic                redirect,
  input  logic [IDX_W-1:0]    redirect_stage,
  input  logic                drain_req,
  input  logic                resume,
  output logic [NUM_REGS-1:0] reg_we,
  output logic [NUM_REGS-1:0] reg_reset,
  output logic [1:0]          state,
  output logic                drained,
  output logic [CNT_W-1:0]    stall_cycles
);
  localparam int HW = RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
  typedef enum logic [1:0] {HOLD, RUN, DRAIN, IDLE} state_t;
  state_t st, st_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [IDX_W-1:0] drain_cnt, drain_n, s_idx;
  logic s_any, rd_ok, drain_stall;
  logic [NUM_REGS-1:0] st_we, st_rst, rd_mask, run_we, run_rst;
  assign state = st;
  assign drained = st == IDLE;
  assign drain_stall = |stall_req[NUM_REGS-1:1];
  // Stall/redirect arbitration: the oldest stalled stage freezes everything younger; an older redirect overrides it
  always_comb begin
    s_any = |stall_req;
    s_idx = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (stall_req[i]) s_idx = IDX_W'(i);
    rd_ok = redirect && redirect_stage != '0 && int'(redirect_stage) < NUM_REGS &&
            !(s_any && s_idx >= redirect_stage);
    for (int i = 0; i < NUM_REGS; i++) begin
      st_we[i] = !(s_any && i <= int'(s_idx));
      st_rst[i] = s_any && i == int'(s_idx) + 1;
      rd_mask[i] = rd_ok && i <= int'(redirect_stage);
    end
    run_we = st_we | rd_mask;
    run_rst = st_rst | (rd_mask & ~NUM_REGS'(1));
  end
  // Per-state output selection; DRAIN blocks new fetches but still lets a redirect load the PC
  always_comb begin
    reg_we = st == RUN ? run_we : st == DRAIN ? {run_we[NUM_REGS-1:1], rd_ok} : '0;
    reg_reset = st == HOLD ? '1 : st == RUN ? run_rst : st == DRAIN ? (run_rst | NUM_REGS'(2)) : '0;
  end
  // Next-state and sequencer counters
  always_comb begin
    st_n = st;
    hold_n = hold_cnt;
    drain_n = drain_cnt;
    case (st)
      HOLD: begin
        hold_n = hold_cnt + 1'b1;
        if (hold_cnt == HW'(RESET_HOLD - 1)) st_n = RUN;
      end
      RUN: if (drain_req) st_n = DRAIN;
      DRAIN:
        if (!drain_req) begin
          st_n = RUN;
          drain_n = '0;
        end else if (!drain_stall) begin
          drain_n = drain_cnt + 1'b1;
          if (drain_cnt == IDX_W'(NUM_REGS - 3)) begin
            st_n = IDLE;
            drain_n = '0;
          end
        end
      IDLE: if (resume) st_n = RUN;
      default: st_n = HOLD;
    endcase
  end
  // State registers and saturating count of fetch-stalled RUN cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= HOLD;
      hold_cnt <= '0;
      drain_cnt <= '0;
      stall_cycles <= '0;
    end else begin
      st <= st_n;
      hold_cnt <= hold_n;
      drain_cnt <= drain_n;
      if (st == RUN && !reg_we[0] && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_flow_ctrl_n.sv
// tb_pipe_flow_ctrl_n: directed checks of hold, stall, redirect, drain/idle and counter saturation
module tb_pipe_flow_ctrl_n;
  logic clk = 0, reset = 0, redirect = 0, drain_req = 0, resume = 0;
  logic [5:0] stall_req = '0, reg_we, reg_reset;
  logic [2:0] redirect_stage = '0;
  logic [1:0] state;
  logic drained;
  logic [3:0] stall_cycles;
  int passed = 0, total = 0, exp_sc = 0;
  pipe_flow_ctrl_n #(.NUM_REGS(6), .IDX_W(3), .RESET_HOLD(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req), .redirect(redirect),
    .redirect_stage(redirect_stage), .drain_req(drain_req), .resume(resume),
    .reg_we(reg_we), .reg_reset(reg_reset), .state(state), .drained(drained),
    .stall_cycles(stall_cycles));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic hold_seq();
    for (int k = 0; k < 4; k++) begin
      settle();
      check("hold_state", 32'(state), 0);
      check("hold_we", 32'(reg_we), 0);
      check("hold_rst", 32'(reg_reset), 32'h3f);
      tick();
    end
    settle();
    check("run_state", 32'(state), 1);
    check("run_we", 32'(reg_we), 32'h3f);
    check("run_rst", 32'(reg_reset), 0);
  endtask
  task automatic drain_to_idle();
    drain_req = 1;
    tick();
    for (int d = 0; d < 4; d++) begin
      settle();
      check("drain_state", 32'(state), 2);
      check("drain_we", 32'(reg_we), 32'h3e);
      check("drain_rst", 32'(reg_reset), 32'h02);
      tick();
    end
    settle();
    check("idle_state", 32'(state), 3);
    check("idle_drained", 32'(drained), 1);
    check("idle_we", 32'(reg_we), 0);
    check("idle_rst", 32'(reg_reset), 0);
  endtask
  initial begin
    repeat (3) tick();
    check("rst_state", 32'(state), 0);
    check("rst_we", 32'(reg_we), 0);
    check("rst_rst", 32'(reg_reset), 32'h3f);
    check("rst_sc", 32'(stall_cycles), 0);
    check("rst_drained", 32'(drained), 0);
    reset = 1;
    hold_seq();
    stall_req = 6'b001000;
    settle();
    check("stall3_we", 32'(reg_we), 32'h30);
    check("stall3_rst", 32'(reg_reset), 32'h10);
    tick();
    check("stall3_sc1", 32'(stall_cycles), 1);
    tick();
    check("stall3_sc2", 32'(stall_cycles), 2);
    redirect = 1;
    redirect_stage = 3;
    stall_req = 6'b000010;
    settle();
    check("redir_we", 32'(reg_we), 32'h3f);
    check("redir_rst", 32'(reg_reset), 32'h0e);
    tick();
    check("redir_sc", 32'(stall_cycles), 2);
    stall_req = 6'b010000;
    settle();
    check("redir_sup_we", 32'(reg_we), 32'h20);
    check("redir_sup_rst", 32'(reg_reset), 32'h20);
    tick();
    check("redir_sup_sc", 32'(stall_cycles), 3);
    stall_req = '0;
    redirect_stage = 0;
    settle();
    check("redir0_rst", 32'(reg_reset), 0);
    redirect_stage = 6;
    settle();
    check("redir6_rst", 32'(reg_reset), 0);
    check("redir6_we", 32'(reg_we), 32'h3f);
    redirect_stage = 5;
    settle();
    check("redir5_rst", 32'(reg_reset), 32'h3e);
    redirect = 0;
    redirect_stage = 0;
    tick();
    exp_sc = 3;
    drain_req = 1;
    settle();
    check("pre_drain_state", 32'(state), 1);
    drain_to_idle();
    resume = 1;
    tick();
    resume = 0;
    check("resume_state", 32'(state), 1);
    check("resume_we", 32'(reg_we), 32'h3f);
    tick();
    for (int d = 0; d < 6; d++) begin
      settle();
      check("drain2_state", 32'(state), 2);
      stall_req = (d == 1 || d == 2) ? 6'b010000 : 6'b000000;
      settle();
      if (d == 1) begin
        check("drain2_stall_we", 32'(reg_we), 32'h20);
        check("drain2_stall_rst", 32'(reg_reset), 32'h22);
      end
      tick();
    end
    stall_req = '0;
    check("drain2_idle", 32'(state), 3);
    drain_req = 0;
    resume = 1;
    tick();
    resume = 0;
    drain_req = 1;
    tick();
    tick();
    tick();
    check("abort_in_drain", 32'(state), 2);
    drain_req = 0;
    tick();
    check("abort_state", 32'(state), 1);
    check("sc_before_sat", 32'(stall_cycles), 32'(exp_sc));
    stall_req = 6'b000001;
    settle();
    check("stall0_we", 32'(reg_we), 32'h3e);
    check("stall0_rst", 32'(reg_reset), 32'h02);
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_sc = exp_sc < 15 ? exp_sc + 1 : 15;
      check("sat_sc", 32'(stall_cycles), 32'(exp_sc));
    end
    check("sat_final", 32'(stall_cycles), 15);
    stall_req = '0;
    drain_to_idle();
    drain_req = 0;
    reset = 0;
    tick();
    check("reidle_state", 32'(state), 0);
    check("reidle_sc", 32'(stall_cycles), 0);
    check("reidle_drained", 32'(drained), 0);
    reset = 1;
    hold_seq();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
